// File: rtl/sram_like_bridge.sv
// sram_like_bridge: converts the core's valid/ready request/response streams
// into an sram-like bus (req / addr_ok / data_ok). Up to MAX_OUT transactions
// may be outstanding, counting both those still waiting for data_ok and
// responses buffered for the core. Responses return in issue order.
// Optional feature macro: BRIDGE_CANCEL_EN. When defined, the cancel input
// discards all in-flight and buffered transactions. Responses that are still
// owed by the bus are then swallowed by a drop counter. When the macro is
// undefined, cancel is ignored and every data_ok produces a response.
module sram_like_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 2
) (
  input  logic                clk,
  input  logic                reset,
  // core request stream
  input  logic                cpu_req_valid,
  output logic                cpu_req_ready,
  input  logic                cpu_req_wr,
  input  logic [1:0]          cpu_req_size,
  input  logic [DATA_W/8-1:0] cpu_req_wstrb,
  input  logic [ADDR_W-1:0]   cpu_req_addr,
  input  logic [DATA_W-1:0]   cpu_req_wdata,
  // core response stream
  output logic                cpu_rsp_valid,
  input  logic                cpu_rsp_ready,
  output logic                cpu_rsp_wr,
  output logic [DATA_W-1:0]   cpu_rsp_rdata,
  // flush
  input  logic                cancel,
  // sram-like bus
  output logic                req,
  output logic                wr,
  output logic [1:0]          size,
  output logic [DATA_W/8-1:0] wstrb,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   wdata,
  input  logic                addr_ok,
  input  logic                data_ok,
  input  logic [DATA_W-1:0]   rdata
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [PW-1:0]   PTR_LAST  = PW'(MAX_OUT - 1);
  localparam logic [CW+1:0]   CRED_MAX  = (CW + 2)'(MAX_OUT);

  // Counters: transactions waiting for data_ok, buffered responses, and
  // bus responses still owed for cancelled transactions.
  logic [CW-1:0] infl_cnt_q, infl_cnt_d;
  logic [CW-1:0] rsp_cnt_q, rsp_cnt_d;
  logic [CW-1:0] drop_cnt_q;

  // Tag FIFO: remembers whether each in-flight transaction is a write.
  logic [MAX_OUT-1:0] tag_mem_q;
  logic [PW-1:0]      tag_wptr_q, tag_wptr_d;
  logic [PW-1:0]      tag_rptr_q, tag_rptr_d;

  // Response FIFO: {wr, data} per entry.
  logic [DATA_W:0]    rsp_mem_q [MAX_OUT];
  logic [PW-1:0]      rsp_wptr_q, rsp_wptr_d;
  logic [PW-1:0]      rsp_rptr_q, rsp_rptr_d;

  logic          cancel_eff;
  logic [CW+1:0] credit;
  logic          can_issue;
  logic          accept;
  logic          dok_live;
  logic          drop_hit;
  logic          tag_pop;
  logic          rsp_push;
  logic          rsp_pop;
  logic          tag_head;
  logic [DATA_W:0] rsp_head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

`ifdef BRIDGE_CANCEL_EN
  logic [CW-1:0] drop_cnt_d;

  assign cancel_eff = cancel;

  // Drop counter: absorbs data_ok beats belonging to cancelled transactions.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (cancel_eff) begin
      drop_cnt_d = drop_cnt_q + infl_cnt_q - (dok_live ? CW'(1) : CW'(0));
    end else if (drop_hit) begin
      drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  // Drop counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end
`else
  logic cancel_unused;

  assign cancel_unused = cancel;
  assign cancel_eff    = 1'b0;
  assign drop_cnt_q    = '0;
`endif

  // Credit covers every transaction the bridge must still account for.
  assign credit    = {2'b00, infl_cnt_q} + {2'b00, rsp_cnt_q} + {2'b00, drop_cnt_q};
  assign can_issue = (credit < CRED_MAX);

  // Request path is a straight pass-through gated by credit and flush.
  assign req           = cpu_req_valid & can_issue & ~cancel_eff & ~reset;
  assign wr            = cpu_req_wr;
  assign size          = cpu_req_size;
  assign wstrb         = cpu_req_wstrb;
  assign addr          = cpu_req_addr;
  assign wdata         = cpu_req_wdata;
  assign accept        = req & addr_ok;
  assign cpu_req_ready = accept;

  // A data_ok with nothing owed is a bus protocol error and is ignored.
  assign dok_live = data_ok & ((infl_cnt_q != '0) | (drop_cnt_q != '0));
  assign drop_hit = dok_live & (drop_cnt_q != '0);
  assign tag_pop  = dok_live & ~drop_hit;
  assign rsp_push = tag_pop & ~cancel_eff;
  assign rsp_pop  = cpu_rsp_valid & cpu_rsp_ready;

  assign tag_head = tag_mem_q[tag_rptr_q];
  assign rsp_head = rsp_mem_q[rsp_rptr_q];

  // Response outputs come from the FIFO head and read as zero when empty.
  assign cpu_rsp_valid = (rsp_cnt_q != '0);
  assign cpu_rsp_wr    = cpu_rsp_valid & rsp_head[DATA_W];
  assign cpu_rsp_rdata = cpu_rsp_valid ? rsp_head[DATA_W-1:0] : '0;

  // Next-state for counters and FIFO pointers; cancel flushes both FIFOs.
  always_comb begin
    infl_cnt_d = infl_cnt_q;
    rsp_cnt_d  = rsp_cnt_q;
    tag_wptr_d = tag_wptr_q;
    tag_rptr_d = tag_rptr_q;
    rsp_wptr_d = rsp_wptr_q;
    rsp_rptr_d = rsp_rptr_q;
    if (accept) begin
      infl_cnt_d = infl_cnt_d + CW'(1);
      tag_wptr_d = ptr_inc(tag_wptr_q);
    end
    if (tag_pop) begin
      infl_cnt_d = infl_cnt_d - CW'(1);
      tag_rptr_d = ptr_inc(tag_rptr_q);
    end
    if (rsp_push) begin
      rsp_cnt_d  = rsp_cnt_d + CW'(1);
      rsp_wptr_d = ptr_inc(rsp_wptr_q);
    end
    if (rsp_pop) begin
      rsp_cnt_d  = rsp_cnt_d - CW'(1);
      rsp_rptr_d = ptr_inc(rsp_rptr_q);
    end
    if (cancel_eff) begin
      infl_cnt_d = '0;
      rsp_cnt_d  = '0;
      tag_wptr_d = '0;
      tag_rptr_d = '0;
      rsp_wptr_d = '0;
      rsp_rptr_d = '0;
    end
  end

  // Counter and pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      infl_cnt_q <= '0;
      rsp_cnt_q  <= '0;
      tag_wptr_q <= '0;
      tag_rptr_q <= '0;
      rsp_wptr_q <= '0;
      rsp_rptr_q <= '0;
    end else begin
      infl_cnt_q <= infl_cnt_d;
      rsp_cnt_q  <= rsp_cnt_d;
      tag_wptr_q <= tag_wptr_d;
      tag_rptr_q <= tag_rptr_d;
      rsp_wptr_q <= rsp_wptr_d;
      rsp_rptr_q <= rsp_rptr_d;
    end
  end

  // FIFO storage writes; contents need no reset since counts gate visibility.
  always_ff @(posedge clk) begin
    if (accept) begin
      tag_mem_q[tag_wptr_q] <= cpu_req_wr;
    end
    if (rsp_push) begin
      rsp_mem_q[rsp_wptr_q] <= {tag_head, (tag_head ? {DATA_W{1'b0}} : rdata)};
    end
  end

endmodule

// File: tb/tb_sram_like_bridge.sv
// Randomized scoreboard bench for sram_like_bridge. A bus-side model keeps
// the list of accepted transactions (with the read data the bus will return)
// and the list of responses the core should see. The monitor compares DUT
// outputs against these lists every cycle. Honours BRIDGE_CANCEL_EN.
module tb_sram_like_bridge;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int MAX_OUT = 2;
  localparam int SW      = DATA_W / 8;
`ifdef BRIDGE_CANCEL_EN
  localparam bit CANCEL_EN = 1'b1;
`else
  localparam bit CANCEL_EN = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              cpu_req_valid;
  logic              cpu_req_ready;
  logic              cpu_req_wr;
  logic [1:0]        cpu_req_size;
  logic [SW-1:0]     cpu_req_wstrb;
  logic [ADDR_W-1:0] cpu_req_addr;
  logic [DATA_W-1:0] cpu_req_wdata;
  logic              cpu_rsp_valid;
  logic              cpu_rsp_ready;
  logic              cpu_rsp_wr;
  logic [DATA_W-1:0] cpu_rsp_rdata;
  logic              cancel;
  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [SW-1:0]     wstrb;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  sram_like_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_wr(cpu_req_wr), .cpu_req_size(cpu_req_size),
    .cpu_req_wstrb(cpu_req_wstrb), .cpu_req_addr(cpu_req_addr),
    .cpu_req_wdata(cpu_req_wdata),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_ready(cpu_rsp_ready),
    .cpu_rsp_wr(cpu_rsp_wr), .cpu_rsp_rdata(cpu_rsp_rdata),
    .cancel(cancel),
    .req(req), .wr(wr), .size(size), .wstrb(wstrb), .addr(addr), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              wr;
    logic [DATA_W-1:0] rdata;
    bit                dropped;
  } bus_t;

  typedef struct {
    logic              wr;
    logic [DATA_W-1:0] rdata;
  } rsp_t;

  bus_t              busq[$];       // accepted by the bus, data_ok not yet seen
  rsp_t              expq[$];       // responses the core is owed, in order
  logic [DATA_W-1:0] next_rdata[$]; // forced read data for directed cases

  int checks;
  int errors;
  int rsp_seen;
  bit acc_last;
  bit post_reset;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard: all comparisons and model updates at the falling edge.
  bus_t b;
  bus_t nb;
  rsp_t e;
  rsp_t ne;
  bit   canc;
  bit   req_exp;
  int   credit;

  always @(negedge clk) begin
    if (reset) begin
      busq.delete();
      expq.delete();
      acc_last   = 1'b0;
      post_reset = 1'b1;
    end else begin
      if (post_reset) begin
        chk("rst_rsp_valid", cpu_rsp_valid, 0);
        chk("rst_rsp_wr", cpu_rsp_wr, 0);
        chk("rst_rsp_rdata", cpu_rsp_rdata, 0);
        chk("rst_req", req, 0);
        chk("rst_req_ready", cpu_req_ready, 0);
        post_reset = 1'b0;
      end
      canc    = CANCEL_EN && cancel;
      credit  = busq.size() + expq.size();
      req_exp = cpu_req_valid && (credit < MAX_OUT) && !canc;
      chk("req", req, req_exp);
      chk("cpu_req_ready", cpu_req_ready, req_exp && addr_ok);
      if (req_exp) begin
        chk("bus_fields", {wr, size, wstrb, addr, wdata},
            {cpu_req_wr, cpu_req_size, cpu_req_wstrb, cpu_req_addr, cpu_req_wdata});
      end
      chk("rsp_valid", cpu_rsp_valid, expq.size() > 0);
      if (cpu_rsp_valid && cpu_rsp_ready && expq.size() > 0) begin
        e = expq.pop_front();
        rsp_seen++;
        $display("rsp %0d: wr=%0b rdata=%08h (model wr=%0b rdata=%08h)",
                 rsp_seen, cpu_rsp_wr, cpu_rsp_rdata, e.wr, e.rdata);
        chk("rsp_wr", cpu_rsp_wr, e.wr);
        chk("rsp_rdata", cpu_rsp_rdata, e.rdata);
      end
      if (data_ok) begin
        chk("data_ok_protocol", busq.size() > 0, 1);
        if (busq.size() > 0) begin
          b = busq.pop_front();
          if (!b.dropped && !canc) begin
            ne.wr    = b.wr;
            ne.rdata = b.wr ? '0 : b.rdata;
            expq.push_back(ne);
          end
        end
      end
      if (canc) begin
        foreach (busq[i]) busq[i].dropped = 1'b1;
        expq.delete();
      end
      acc_last = req_exp && addr_ok;
      if (acc_last) begin
        nb.wr      = cpu_req_wr;
        nb.dropped = 1'b0;
        if (!cpu_req_wr && next_rdata.size() > 0) nb.rdata = next_rdata.pop_front();
        else nb.rdata = $urandom;
        busq.push_back(nb);
      end
    end
  end

  // Drive n cycles with percentage knobs: request valid, addr_ok, data_ok,
  // response ready, cancel. A pending request is held until accepted.
  task automatic run(input int n, input int pv, input int pa, input int pd,
                     input int pr, input int pc);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      if (!cpu_req_valid || acc_last) begin
        cpu_req_valid = ($urandom_range(99) < pv);
        cpu_req_wr    = 1'($urandom_range(1));
        cpu_req_size  = 2'($urandom_range(2));
        cpu_req_wstrb = SW'($urandom);
        cpu_req_addr  = ADDR_W'($urandom);
        cpu_req_wdata = DATA_W'($urandom);
      end
      addr_ok       = ($urandom_range(99) < pa);
      data_ok       = (busq.size() > 0) && ($urandom_range(99) < pd);
      rdata         = (data_ok && !busq[0].wr) ? busq[0].rdata : DATA_W'($urandom);
      cpu_rsp_ready = ($urandom_range(99) < pr);
      cancel        = ($urandom_range(99) < pc);
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    reset         = 1'b1;
    cpu_req_valid = 1'b0;
    addr_ok       = 1'b0;
    data_ok       = 1'b0;
    cpu_rsp_ready = 1'b0;
    cancel        = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rsp_seen      = 0;
    acc_last      = 1'b0;
    post_reset    = 1'b0;
    reset         = 1'b1;
    cpu_req_valid = 1'b0;
    cpu_req_wr    = 1'b0;
    cpu_req_size  = 2'd0;
    cpu_req_wstrb = '0;
    cpu_req_addr  = '0;
    cpu_req_wdata = '0;
    cpu_rsp_ready = 1'b0;
    cancel        = 1'b0;
    addr_ok       = 1'b0;
    data_ok       = 1'b0;
    rdata         = '0;
    do_reset(3);

    // Single read at 0x1000, data_ok three cycles later with 0xDEADBEEF.
    next_rdata.push_back(32'hDEADBEEF);
    @(posedge clk);
    #1;
    cpu_req_valid = 1'b1;
    cpu_req_wr    = 1'b0;
    cpu_req_size  = 2'd2;
    cpu_req_wstrb = '1;
    cpu_req_addr  = 32'h0000_1000;
    cpu_req_wdata = '0;
    addr_ok       = 1'b1;
    cpu_rsp_ready = 1'b1;
    run(2, 0, 100, 0, 100, 0);
    run(1, 0, 100, 100, 100, 0);
    run(3, 0, 100, 0, 100, 0);

    // Credit limit: bus accepts everything, data withheld, then released.
    run(6, 100, 100, 0, 100, 0);
    run(10, 100, 100, 100, 100, 0);

    // Response backpressure with buffered responses, then drain.
    run(4, 100, 100, 100, 0, 0);
    run(5, 100, 100, 0, 0, 0);
    run(10, 0, 100, 100, 100, 0);

    // Cancel with transactions in flight, then fresh traffic.
    run(3, 100, 100, 0, 100, 0);
    run(1, 0, 100, 0, 100, 100);
    run(10, 100, 100, 100, 100, 0);
    run(2, 100, 100, 0, 0, 0);
    run(1, 0, 100, 100, 0, 100);
    run(10, 100, 100, 100, 100, 0);

    // Reset mid-flight, then normal traffic.
    run(4, 100, 100, 50, 0, 0);
    do_reset(1);
    run(10, 100, 100, 100, 100, 0);

    // Randomised mixes.
    run(1500, 70, 70, 60, 70, 3);
    run(800, 100, 100, 100, 100, 0);
    run(800, 90, 40, 30, 30, 5);

    // Drain and confirm nothing is left owed.
    run(40, 0, 100, 100, 100, 0);
    chk("drain_bus", busq.size(), 0);
    chk("drain_rsp", expq.size(), 0);
    chk("saw_responses", rsp_seen > 20, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
